// File: rtl/popcount_kgen_pkg.sv
// Shared defaults, FSM state encoding and mask helper for the k-combination generator.
package popcount_kgen_pkg;

    localparam int N_DEF  = 23;
    localparam int CW_DEF = 5;
    localparam int BW_DEF = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Bit i of the top-k mask ((1<<k)-1) << (n-k): set when i lies in the k highest positions.
    function automatic logic in_top_k(input int n, input int kk, input int i);
        return (i >= n - kk);
    endfunction

endpackage

// File: rtl/popcount_kgen_next.sv
// Combinational Gosper step: next larger N-bit value with the same popcount as v.
module popcount_kgen_next #(
    parameter int N = 23
) (
    input  logic [N-1:0] v,
    output logic [N-1:0] nxt
);

    localparam int SW = $clog2(N + 3);

    logic [N:0]    v_w;
    logic [N:0]    c_w;
    logic [N:0]    r_w;
    logic [N:0]    x_w;
    logic [N:0]    s_w;
    logic [SW-1:0] tz;
    logic          unused_hi;

    always_comb begin
        tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) tz = SW'(i);
        end
        // Carried at N+1 bits so the ripple out of the top-k mask cannot alias.
        v_w = {1'b0, v};
        c_w = v_w & (~v_w + 1'b1);
        r_w = v_w + c_w;
        x_w = r_w ^ v_w;
        s_w = x_w >> (tz + SW'(2));
        nxt = r_w[N-1:0] | s_w[N-1:0];
    end

    assign unused_hi = r_w[N] ^ s_w[N];

endmodule

// File: rtl/popcount_kgen.sv
// Enumerates every N-bit vector of weight k in ascending order over a valid/ready stream.
// Define POPCOUNT_KGEN_BEATCNT_EN to build the accepted-beat counter; otherwise beat_cnt is 0.
module popcount_kgen
    import popcount_kgen_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] k,
    output logic          busy,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec,
    output logic          vec_last,
    output logic          done,
    output logic          err,
    output logic [BW-1:0] beat_cnt
);

    // Stream contract: a beat transfers on a rising edge where vec_valid & vec_ready;
    // while vec_valid & !vec_ready, vec, vec_last and beat_cnt do not change.

    state_e        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [CW-1:0] k_q, k_d;
    logic          err_q, err_d;

    logic [N-1:0]  vec_nxt;
    logic [N-1:0]  top_mask;
    logic [N-1:0]  low_mask;
    logic          k_ok;
    logic          load;
    logic          accept;
    logic          is_last;

    popcount_kgen_next #(.N(N)) u_next (
        .v   (vec_q),
        .nxt (vec_nxt)
    );

    always_comb begin
        top_mask = '0;
        low_mask = '0;
        for (int i = 0; i < N; i++) begin
            top_mask[i] = in_top_k(N, int'(k_q), i);
            low_mask[i] = (i < int'(k));
        end
    end

    assign k_ok      = (int'(k) <= N);
    assign load      = (state_q == IDLE) && start && k_ok;
    assign is_last   = (vec_q == top_mask);
    assign vec_valid = (state_q == RUN);
    assign accept    = vec_valid && vec_ready;
    assign vec_last  = vec_valid && is_last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;
    assign vec       = vec_q;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        k_d     = k_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_ok) begin
                        vec_d   = low_mask;
                        k_d     = k;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (is_last) state_d = FIN;
                    else         vec_d   = vec_nxt;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

`ifdef POPCOUNT_KGEN_BEATCNT_EN
    logic [BW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)        cnt_d = '0;
        else if (accept) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;
`else
    assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_popcount_kgen.sv
// Directed bench for popcount_kgen: weight classes 0, 1, 2, 23, error start, stray start, reset mid-run.
module tb_popcount_kgen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  k;
    logic        busy;
    logic        vec_valid;
    logic        vec_ready;
    logic [22:0] vec;
    logic        vec_last;
    logic        done;
    logic        err;
    logic [20:0] beat_cnt;

    logic [22:0] exp_q[$];
    int          total;
    int          bad;
    int          beats;

    popcount_kgen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec       (vec),
        .vec_last  (vec_last),
        .done      (done),
        .err       (err),
        .beat_cnt  (beat_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef POPCOUNT_KGEN_BEATCNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'(0);
`endif
    endfunction

    function automatic logic [22:0] top_mask(input int kk);
        logic [63:0] m;
        m = ((64'd1 << kk) - 64'd1) << (23 - kk);
        return m[22:0];
    endfunction

    // scoreboard: expected vectors, ascending, from an independent model
    task automatic fill_exp(input int kk, input int cnt);
        logic [63:0] m;
        logic [22:0] v;
        exp_q.delete();
        if (kk == 1) begin
            for (int i = 0; i < 23; i++) exp_q.push_back(23'(1) << i);
        end else if (kk == 2) begin
            for (int j = 1; j < 23; j++)
                for (int i = 0; i < j; i++)
                    exp_q.push_back((23'(1) << j) | (23'(1) << i));
        end else begin
            m = (64'd1 << kk) - 64'd1;
            v = m[22:0];
            exp_q.push_back(v);
            while (exp_q.size() < cnt) begin
                v = v + 23'd1;
                if ($countones(v) == kk) exp_q.push_back(v);
            end
        end
    endtask

    // driver: start a run, consume up to max_beats beats, optionally with random backpressure
    task automatic run_enum(input int kk, input int max_beats, input bit rnd, output int nb);
        logic [22:0] ev;
        logic [22:0] tm;
        logic [22:0] held_v;
        logic [20:0] held_c;
        bit          stalled;
        bit          rdy;
        int          guard;
        tm      = top_mask(kk);
        nb      = 0;
        guard   = 0;
        stalled = 1'b0;
        held_v  = '0;
        held_c  = '0;
        start   = 1'b1;
        k       = 5'(kk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        while (exp_q.size() > 0 && nb < max_beats && guard < 5000) begin
            guard++;
            chk("valid", 32'(vec_valid), 32'd1);
            if (stalled) begin
                chk("hold_vec", 32'(vec), 32'(held_v));
                chk("hold_cnt", 32'(beat_cnt), 32'(held_c));
            end
            ev = exp_q[0];
            chk("vec", 32'(vec), 32'(ev));
            chk("last", 32'(vec_last), 32'(ev == tm));
            chk("pop", 32'($countones(vec)), 32'(kk));
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vec_ready = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                nb++;
                stalled = 1'b0;
            end else begin
                held_v  = vec;
                held_c  = beat_cnt;
                stalled = 1'b1;
            end
            @(negedge clk);
        end
        vec_ready = 1'b0;
        if (guard >= 5000) chk("run_timeout", 32'(guard), 32'd0);
    endtask

    task automatic fin_check(input string tag, input int n);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_fin_valid"}, 32'(vec_valid), 32'd0);
        chk({tag, "_fin_busy"}, 32'(busy), 32'd1);
        chk({tag, "_cnt"}, 32'(beat_cnt), exp_cnt(n));
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"}, 32'(vec), 32'd0);
        chk({tag, "_valid"}, 32'(vec_valid), 32'd0);
        chk({tag, "_last"}, 32'(vec_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cnt"}, 32'(beat_cnt), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        k         = '0;
        vec_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_hi");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_lo");

        // k=0 with a stray k>N start while running and one stall cycle
        start = 1'b1;
        k     = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("k0_valid", 32'(vec_valid), 32'd1);
        chk("k0_vec", 32'(vec), 32'd0);
        chk("k0_last", 32'(vec_last), 32'd1);
        start = 1'b1;
        k     = 5'd24;
        @(negedge clk);
        start = 1'b0;
        chk("k0_no_err", 32'(err), 32'd0);
        chk("k0_hold_valid", 32'(vec_valid), 32'd1);
        chk("k0_hold_vec", 32'(vec), 32'd0);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        fin_check("k0", 1);

        // k=1, always ready
        fill_exp(1, 23);
        run_enum(1, 1000, 1'b0, beats);
        chk("k1_beats", 32'(beats), 32'd23);
        fin_check("k1", 23);

        // k=2, random backpressure
        fill_exp(2, 253);
        chk("k2_exp0", 32'(exp_q[0]), 32'h000003);
        chk("k2_exp2", 32'(exp_q[2]), 32'h000006);
        run_enum(2, 1000, 1'b1, beats);
        chk("k2_beats", 32'(beats), 32'd253);
        fin_check("k2", 253);

        // k=23 then k=24 error
        fill_exp(23, 1);
        run_enum(23, 10, 1'b0, beats);
        chk("k23_beats", 32'(beats), 32'd1);
        fin_check("k23", 1);
        start = 1'b1;
        k     = 5'd24;
        @(negedge clk);
        start = 1'b0;
        chk("k24_err", 32'(err), 32'd1);
        chk("k24_valid", 32'(vec_valid), 32'd0);
        chk("k24_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("k24_err_off", 32'(err), 32'd0);
        chk("k24_idle", 32'(busy), 32'd0);
        chk("k24_cnt_kept", 32'(beat_cnt), exp_cnt(1));

        // k=11 aborted by reset after 1000 beats
        fill_exp(11, 1001);
        run_enum(11, 1000, 1'b0, beats);
        chk("k11_beats", 32'(beats), 32'd1000);
        chk("k11_cnt", 32'(beat_cnt), exp_cnt(1000));
        chk("k11_next", 32'(vec), 32'(exp_q[0]));
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // k=3 restart after reset
        fill_exp(3, 4);
        chk("k3_exp3", 32'(exp_q[3]), 32'h00000e);
        run_enum(3, 4, 1'b0, beats);
        chk("k3_beats", 32'(beats), 32'd4);
        chk("k3_cnt", 32'(beat_cnt), exp_cnt(4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
